// File: rtl/bolt_pkg.sv
// Shared types and helpers for the player-bolt fire scheduler.
// Holds the FSM state encoding, the coordinate type and the muzzle-position arithmetic.
package bolt_pkg;

    localparam int unsigned COORD_W  = 11;
    localparam int unsigned SUM_W    = COORD_W + 1;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_LAUNCH  = 2'd2
    } fire_state_t;

    // Muzzle X: add the offset one bit wider, then clamp to the right edge.
    function automatic coord_t muzzle_x(input coord_t px, input int unsigned off,
                                        input int unsigned xmax);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, px} + SUM_W'(off);
        return (sum > SUM_W'(xmax)) ? COORD_W'(xmax) : sum[COORD_W-1:0];
    endfunction

    // Muzzle Y: subtract the offset, floored at the top of the screen.
    function automatic coord_t muzzle_y(input coord_t py, input int unsigned off);
        return (py >= COORD_W'(off)) ? (py - COORD_W'(off)) : '0;
    endfunction

endpackage

// File: rtl/bolt_slot_alloc.sv
// Combinational lowest-free-index priority encoder over the bolt slots.
// anyFree is low when every slot is flying; freeIdx is then 0.
module bolt_slot_alloc
    import bolt_pkg::*;
#(
    parameter int unsigned NUM_BOLTS = 4,
    parameter int unsigned IDX_W     = 2
)(
    input  logic [NUM_BOLTS-1:0] boltActive,
    output logic [IDX_W-1:0]     freeIdx,
    output logic                 anyFree
);

    // Scan from the top so the lowest free slot is the last (winning) assignment.
    always_comb begin
        freeIdx = '0;
        anyFree = 1'b0;
        for (int i = NUM_BOLTS - 1; i >= 0; i--) begin
            if (!boltActive[i]) begin
                freeIdx = IDX_W'(i);
                anyFree = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bolt_fire_scheduler.sv
// Turns fire-key presses into rate-limited bolt launches and tracks which slots are flying.
// A grant on startOfFrame produces the launch pulse and muzzle coordinates on the following cycle.
module bolt_fire_scheduler
    import bolt_pkg::*;
#(
    parameter int unsigned NUM_BOLTS       = 4,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned GUN_OFFSET_X    = 14,
    parameter int unsigned GUN_OFFSET_Y    = 4,
    parameter int unsigned TOP_LIMIT_Y     = 8,
    parameter int unsigned X_MAX           = SCREEN_W - 1
)(
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic                         gameActive,
    input  logic                         fireKey,
    input  coord_t                       playerX,
    input  coord_t                       playerY,
    input  logic [NUM_BOLTS*COORD_W-1:0] boltY,
    input  logic [NUM_BOLTS-1:0]         boltHit,
    output logic [NUM_BOLTS-1:0]         boltActive,
    output logic [NUM_BOLTS-1:0]         launch,
    output coord_t                       launchX,
    output coord_t                       launchY,
    output logic                         cooldownBusy,
    output logic [15:0]                  shotsFired
);

    localparam int unsigned IDX_W = (NUM_BOLTS > 1) ? $clog2(NUM_BOLTS) : 1;
    localparam int unsigned CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    fire_state_t           r_state;
    logic                  r_keyPrev;
    logic [IDX_W-1:0]      r_idx;
    logic [CD_W-1:0]       r_cooldown;

    logic [IDX_W-1:0]      w_freeIdx;
    logic                  w_anyFree;
    logic                  w_rise;
    logic                  w_grant;
    logic [NUM_BOLTS-1:0]  w_atTop;
    logic [NUM_BOLTS-1:0]  w_grantOh;
    logic [NUM_BOLTS-1:0]  w_protect;
    logic [NUM_BOLTS-1:0]  w_retire;

    bolt_slot_alloc #(
        .NUM_BOLTS (NUM_BOLTS),
        .IDX_W     (IDX_W)
    ) u_alloc (
        .boltActive (boltActive),
        .freeIdx    (w_freeIdx),
        .anyFree    (w_anyFree)
    );

    always_comb begin
        w_atTop = '0;
        for (int i = 0; i < NUM_BOLTS; i++) begin
            w_atTop[i] = (boltY[i*COORD_W +: COORD_W] <= COORD_W'(TOP_LIMIT_Y));
        end
    end

    // The slot being launched this cycle cannot be retired by a same-cycle hit or limit.
    assign w_rise    = fireKey && !r_keyPrev;
    assign w_grantOh = NUM_BOLTS'(1) << w_freeIdx;
    assign w_protect = (r_state == ST_LAUNCH) ? (NUM_BOLTS'(1) << r_idx) : '0;
    assign w_retire  = (boltHit | (startOfFrame ? w_atTop : '0)) & ~w_protect;
    assign w_grant   = (r_state == ST_PENDING) && startOfFrame && w_anyFree && (r_cooldown == '0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= ST_IDLE;
            r_keyPrev    <= 1'b0;
            r_idx        <= '0;
            r_cooldown   <= '0;
            boltActive   <= '0;
            launch       <= '0;
            launchX      <= '0;
            launchY      <= '0;
            cooldownBusy <= 1'b0;
            shotsFired   <= '0;
        end else begin
            r_keyPrev <= fireKey;
            if (!gameActive) begin
                r_state      <= ST_IDLE;
                r_cooldown   <= '0;
                boltActive   <= '0;
                launch       <= '0;
                cooldownBusy <= 1'b0;
            end else begin
                launch     <= w_grant ? w_grantOh : '0;
                boltActive <= (boltActive & ~w_retire) | (w_grant ? w_grantOh : '0);

                // Grant loads the cooldown; otherwise it counts frames down to zero.
                if (w_grant) begin
                    r_idx        <= w_freeIdx;
                    r_cooldown   <= CD_W'(COOLDOWN_FRAMES);
                    cooldownBusy <= (COOLDOWN_FRAMES != 0);
                    launchX      <= muzzle_x(playerX, GUN_OFFSET_X, X_MAX);
                    launchY      <= muzzle_y(playerY, GUN_OFFSET_Y);
                    shotsFired   <= shotsFired + 16'd1;
                end else if (startOfFrame && (r_cooldown != '0)) begin
                    r_cooldown   <= r_cooldown - CD_W'(1);
                    cooldownBusy <= (r_cooldown != CD_W'(1));
                end

                case (r_state)
                    ST_IDLE:    if (w_rise) r_state <= ST_PENDING;
                    ST_PENDING: if (startOfFrame) r_state <= w_grant ? ST_LAUNCH : ST_IDLE;
                    ST_LAUNCH:  r_state <= ST_IDLE;
                    default:    r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bolt_fire_scheduler.sv
// Self-checking bench for bolt_fire_scheduler: directed scenarios, a coordinate table,
// then random stimulus, all compared every cycle against a rule-level reference model.
module tb_bolt_fire_scheduler;

    localparam int NB = 4;
    localparam int CW = 11;

    logic              clk = 1'b0;
    logic              resetN;
    logic              startOfFrame;
    logic              gameActive;
    logic              fireKey;
    logic [CW-1:0]     playerX;
    logic [CW-1:0]     playerY;
    logic [NB*CW-1:0]  boltY;
    logic [NB-1:0]     boltHit;
    logic [NB-1:0]     boltActive;
    logic [NB-1:0]     launch;
    logic [CW-1:0]     launchX;
    logic [CW-1:0]     launchY;
    logic              cooldownBusy;
    logic [15:0]       shotsFired;

    bolt_fire_scheduler dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .gameActive   (gameActive),
        .fireKey      (fireKey),
        .playerX      (playerX),
        .playerY      (playerY),
        .boltY        (boltY),
        .boltHit      (boltHit),
        .boltActive   (boltActive),
        .launch       (launch),
        .launchX      (launchX),
        .launchY      (launchY),
        .cooldownBusy (cooldownBusy),
        .shotsFired   (shotsFired)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: request flag, slot occupancy, frames left to wait, shot tally.
    bit m_act[NB];
    bit m_pending;
    bit m_keyPrev;
    int m_launching;
    int m_cd;
    int m_shots;
    int m_lx;
    int m_ly;

    typedef struct {
        int px;
        int py;
        int ex;
        int ey;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NB; i++) m_act[i] = 1'b0;
        m_pending   = 1'b0;
        m_keyPrev   = 1'b0;
        m_launching = -1;
        m_cd        = 0;
        m_shots     = 0;
        m_lx        = 0;
        m_ly        = 0;
    endtask

    task automatic m_step();
        bit nact[NB];
        bit rise;
        int g;
        rise = fireKey && !m_keyPrev;
        m_keyPrev = fireKey;
        if (!gameActive) begin
            for (int i = 0; i < NB; i++) m_act[i] = 1'b0;
            m_pending   = 1'b0;
            m_launching = -1;
            m_cd        = 0;
            return;
        end
        g = -1;
        if (m_pending) begin
            if (startOfFrame) begin
                m_pending = 1'b0;
                if (m_cd == 0)
                    for (int i = 0; i < NB; i++)
                        if (!m_act[i] && g < 0) g = i;
            end
        end else if (m_launching < 0 && rise) begin
            m_pending = 1'b1;
        end
        for (int i = 0; i < NB; i++) begin
            nact[i] = m_act[i];
            if (m_act[i] && i != m_launching &&
                (boltHit[i] || (startOfFrame && int'(boltY[i*CW +: CW]) <= 8)))
                nact[i] = 1'b0;
        end
        if (g >= 0) begin
            nact[g] = 1'b1;
            m_cd    = 8;
            m_shots = (m_shots + 1) % 65536;
            m_lx    = (int'(playerX) + 14 > 639) ? 639 : int'(playerX) + 14;
            m_ly    = (int'(playerY) >= 4) ? int'(playerY) - 4 : 0;
        end else if (startOfFrame && m_cd > 0) begin
            m_cd--;
        end
        m_launching = g;
        for (int i = 0; i < NB; i++) m_act[i] = nact[i];
    endtask

    function automatic int exp_act();
        int v = 0;
        for (int i = 0; i < NB; i++) if (m_act[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic compare();
        chk("boltActive", 32'(boltActive), 32'(exp_act()));
        chk("launch", 32'(launch), (m_launching >= 0) ? 32'(1 << m_launching) : 32'd0);
        chk("cooldownBusy", 32'(cooldownBusy), 32'(m_cd != 0));
        chk("shotsFired", 32'(shotsFired), 32'(m_shots));
        if (m_launching >= 0) begin
            chk("launchX", 32'(launchX), 32'(m_lx));
            chk("launchY", 32'(launchY), 32'(m_ly));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!resetN) m_reset();
        else m_step();
        #1;
        compare();
    endtask

    task automatic press();
        fireKey = 1'b1;
        tick();
        fireKey = 1'b0;
        tick();
    endtask

    task automatic frame_check(input logic [NB-1:0] expLaunch, input string name);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        chk(name, 32'(launch), 32'(expLaunch));
        tick();
    endtask

    task automatic blank(input int n);
        repeat (n) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic set_y(input int slot, input int y);
        boltY[slot*CW +: CW] = CW'(y);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{100, 440, 114, 436};
        tbl[1] = '{630, 2, 639, 0};
        tbl[2] = '{625, 4, 639, 0};
        tbl[3] = '{624, 5, 638, 1};
        tbl[4] = '{0, 3, 14, 0};
        tbl[5] = '{2047, 2047, 639, 2043};

        resetN = 1'b0;
        startOfFrame = 1'b0;
        gameActive = 1'b0;
        fireKey = 1'b0;
        playerX = '0;
        playerY = '0;
        boltHit = '0;
        for (int i = 0; i < NB; i++) set_y(i, 200);
        m_reset();
        tick();
        tick();
        chk("reset_boltActive", 32'(boltActive), 32'd0);
        chk("reset_launch", 32'(launch), 32'd0);
        chk("reset_shots", 32'(shotsFired), 32'd0);
        chk("reset_busy", 32'(cooldownBusy), 32'd0);
        resetN = 1'b1;

        // Single press launches slot 0 one cycle after the frame pulse.
        gameActive = 1'b1;
        playerX = 11'd100;
        playerY = 11'd440;
        tick();
        press();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        chk("t1_launch", 32'(launch), 32'd1);
        chk("t1_launchX", 32'(launchX), 32'd114);
        chk("t1_launchY", 32'(launchY), 32'd436);
        chk("t1_boltActive", 32'(boltActive), 32'd1);
        chk("t1_shots", 32'(shotsFired), 32'd1);
        chk("t1_busy", 32'(cooldownBusy), 32'd1);
        tick();

        // One press per frame: only the ninth frame after the load launches.
        for (int k = 1; k <= 10; k++) begin
            press();
            frame_check((k == 9) ? NB'(2) : NB'(0), "t2_launch");
            if (k == 7) chk("t2_busy_f7", 32'(cooldownBusy), 32'd1);
            if (k == 8) chk("t2_busy_f8", 32'(cooldownBusy), 32'd0);
        end

        // Fill every slot, then a press is dropped; a hit frees slot 2 for reuse.
        blank(8);
        press();
        frame_check(NB'(4), "t3_slot2");
        blank(8);
        press();
        frame_check(NB'(8), "t3_slot3");
        blank(8);
        press();
        frame_check(NB'(0), "t3_full_nolaunch");
        chk("t3_shots_held", 32'(shotsFired), 32'd4);
        chk("t3_all_active", 32'(boltActive), 32'hF);
        boltHit = NB'(4);
        tick();
        boltHit = '0;
        chk("t3_hit_clear", 32'(boltActive), 32'hB);
        press();
        frame_check(NB'(4), "t3_reuse2");
        chk("t3_shots", 32'(shotsFired), 32'd5);

        // Slot 0 retiring on the granting frame is not available to that grant.
        blank(8);
        press();
        set_y(0, 8);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        chk("t4_no_launch", 32'(launch), 32'd0);
        chk("t4_top_clear", 32'(boltActive), 32'hE);
        set_y(0, 200);
        tick();
        press();
        frame_check(NB'(1), "t4_slot0");
        chk("t4_shots", 32'(shotsFired), 32'd6);

        // Muzzle coordinate table, each entry from a flushed state.
        foreach (tbl[n]) begin
            gameActive = 1'b0;
            tick();
            gameActive = 1'b1;
            playerX = CW'(tbl[n].px);
            playerY = CW'(tbl[n].py);
            press();
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            chk("t5_launch", 32'(launch), 32'd1);
            chk("t5_launchX", 32'(launchX), 32'(tbl[n].ex));
            chk("t5_launchY", 32'(launchY), 32'(tbl[n].ey));
            tick();
        end

        // gameActive drop while pending with three slots flying.
        gameActive = 1'b0;
        tick();
        gameActive = 1'b1;
        press();
        frame_check(NB'(1), "t6_slot0");
        blank(8);
        press();
        frame_check(NB'(2), "t6_slot1");
        blank(8);
        press();
        frame_check(NB'(4), "t6_slot2");
        press();
        gameActive = 1'b0;
        tick();
        chk("t6_flush_active", 32'(boltActive), 32'd0);
        chk("t6_flush_busy", 32'(cooldownBusy), 32'd0);
        chk("t6_flush_launch", 32'(launch), 32'd0);
        gameActive = 1'b1;
        tick();
        press();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        chk("t6_pre_reset_launch", 32'(launch), 32'd1);
        resetN = 1'b0;
        #1;
        chk("t6_async_launch", 32'(launch), 32'd0);
        chk("t6_async_active", 32'(boltActive), 32'd0);
        chk("t6_async_x", 32'(launchX), 32'd0);
        chk("t6_async_y", 32'(launchY), 32'd0);
        chk("t6_async_busy", 32'(cooldownBusy), 32'd0);
        chk("t6_async_shots", 32'(shotsFired), 32'd0);
        m_reset();
        tick();
        resetN = 1'b1;
        tick();

        // Random traffic checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            fireKey      = ($urandom_range(0, 3) == 0);
            startOfFrame = ($urandom_range(0, 5) == 0);
            gameActive   = ($urandom_range(0, 199) != 0);
            playerX      = CW'($urandom_range(0, 2047));
            playerY      = CW'($urandom_range(0, 2047));
            boltHit      = ($urandom_range(0, 7) == 0) ? NB'($urandom_range(0, 15)) : '0;
            for (int i = 0; i < NB; i++)
                set_y(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12))
                                                     : int'($urandom_range(9, 479)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
